// File: rtl/wb_pkg.sv
// Shared Wishbone B3 definitions: cycle/burst type codes, responder FSM
// states and the registered-feedback burst address stepping function.
package wb_pkg;

  // Cycle type identifiers (wb_cti)
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  // Burst type extensions (wb_bte)
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // Widest byte address the burst helper handles; callers cast to their width
  localparam int WB_ADR_MAX = 64;
  typedef logic [WB_ADR_MAX-1:0] wb_adr_t;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BEAT,
    ST_RECOVER
  } wb_state_t;

  // Next byte address of a burst: 4-byte step, linear carries through the
  // whole address, wrap modes only step the low word-address bits.
  function automatic wb_adr_t wb_burst_next(input wb_adr_t adr, input logic [1:0] bte);
    wb_adr_t nxt;
    nxt = adr + wb_adr_t'(4);
    case (bte)
      BTE_WRAP4:  nxt = {adr[WB_ADR_MAX-1:4], adr[3:2] + 2'd1, adr[1:0]};
      BTE_WRAP8:  nxt = {adr[WB_ADR_MAX-1:5], adr[4:2] + 3'd1, adr[1:0]};
      BTE_WRAP16: nxt = {adr[WB_ADR_MAX-1:6], adr[5:2] + 4'd1, adr[1:0]};
      default:    nxt = adr + wb_adr_t'(4);
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wb_ext_ram.sv
// Byte-enabled 32-bit word memory: combinational read port, clocked write
// port. Contents are never reset.
module wb_ext_ram #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [3:0]       wsel,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEM_WORDS];

  assign rdata = mem[raddr];

  // Update only the byte lanes selected for this write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wsel[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/wb_ext_responder.sv
// Wishbone B3 slave terminating the external bus port with a local memory.
// Handles classic cycles and incrementing/wrapping registered-feedback
// bursts, optional wait states before the first beat, and out-of-window
// accesses answered by err (or by a dummy ack when ERR_ON_OOR=0).
module wb_ext_responder
  import wb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter int                    ERR_ON_OOR  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic [2:0]              wb_cti_i,
  input  logic [1:0]              wb_bte_i,
  input  logic                    wb_cab_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int WCNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  // Window bounds, one bit wider so BASE + size cannot overflow
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(4 * MEM_WORDS);

  wb_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic [WCNT_W-1:0]     wait_reg, wait_next;
  logic                  ack_reg, ack_next;
  logic                  err_reg, err_next;
  logic [DATA_WIDTH-1:0] dat_reg, dat_next;

  logic                  req;
  logic [ADDR_WIDTH-1:0] adr_word;
  logic [ADDR_WIDTH-1:0] cnt_adv;
  logic [ADDR_WIDTH-1:0] cur_off, next_off;
  logic                  cur_in, next_in, beat_next;
  logic                  mem_we;
  logic [31:0]           mem_rdata;

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] ax;
    ax = {1'b0, a};
    return (ax >= WIN_LO) && (ax < WIN_HI);
  endfunction

  assign req      = wb_cyc_i & wb_stb_i;
  assign adr_word = {wb_adr_i[ADDR_WIDTH-1:2], 2'b00};
  assign cnt_adv  = ADDR_WIDTH'(wb_burst_next(wb_adr_t'(cnt_reg), wb_bte_i));

  // Current beat uses cnt_reg; the beat being set up for next cycle uses cnt_next
  assign cur_off  = cnt_reg - BASE_ADDR;
  assign next_off = cnt_next - BASE_ADDR;
  assign cur_in   = in_window(cnt_reg);
  assign next_in  = in_window(cnt_next);

  assign wb_rty_o = 1'b0;
  assign wb_ack_o = ack_reg;
  assign wb_err_o = err_reg;
  assign wb_dat_o = dat_reg;

  logic unused_ok;
  assign unused_ok = ^{wb_cab_i, wb_adr_i[1:0], cur_off[ADDR_WIDTH-1:IDX_W+2], cur_off[1:0],
                       next_off[ADDR_WIDTH-1:IDX_W+2], next_off[1:0]};

  wb_ext_ram #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cur_off[IDX_W+1:2]),
    .wsel  (wb_sel_i),
    .wdata (wb_dat_i),
    .raddr (next_off[IDX_W+1:2]),
    .rdata (mem_rdata)
  );

  // Next state, burst counter, wait counter and memory write strobe
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wait_next  = wait_reg;
    mem_we     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (req) begin
          cnt_next = adr_word;
          if (WAIT_STATES > 0) begin
            state_next = ST_WAIT;
            wait_next  = WCNT_W'(WAIT_STATES - 1);
          end else begin
            state_next = ST_BEAT;
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_next = ST_IDLE;
        end else if (wait_reg == '0) begin
          state_next = ST_BEAT;
        end else begin
          wait_next = wait_reg - WCNT_W'(1);
        end
      end
      ST_BEAT: begin
        if (!req) begin
          // Master withdrew: unacknowledged beat is dropped
          state_next = ST_IDLE;
        end else begin
          // Beat completes here; out-of-window writes never reach memory
          mem_we = wb_we_i & cur_in;
          if (err_reg || (wb_cti_i != CTI_INCR)) begin
            state_next = ST_RECOVER;
          end else begin
            cnt_next = cnt_adv;
          end
        end
      end
      ST_RECOVER: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Registered response for the beat presented in the next cycle
  always_comb begin
    beat_next = (state_next == ST_BEAT);
    ack_next  = beat_next & (next_in | (ERR_ON_OOR == 0));
    err_next  = beat_next & ~next_in & (ERR_ON_OOR != 0);
    dat_next  = (beat_next && next_in) ? mem_rdata : '0;
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      wait_reg  <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      dat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wait_reg  <= wait_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      dat_reg   <= dat_next;
    end
  end

endmodule
